// File: rtl/rstmgr_pkg.sv
// Shared types and defaults for the rstmgr software reset control slice.
package rstmgr_pkg;

    localparam int unsigned NumSwResetsDefault = 8;

    // Pairwise Hamming distance is 4, so a single upset cannot land on another legal state.
    typedef enum logic [5:0] {
        SwRstIdle     = 6'b101001,
        SwRstHold     = 6'b010011,
        SwRstAsserted = 6'b110100
    } sw_rst_state_e;

endpackage

// File: rtl/rstmgr_sw_rst_chan.sv
// One software reset channel: sparse FSM, minimum-width counter and pending-release flag.
module rstmgr_sw_rst_chan
    import rstmgr_pkg::*;
#(
    parameter int unsigned MinAssertCycles = 4,
    localparam int unsigned CntW = $clog2(MinAssertCycles + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wr0,
    input  logic wr1,
    output logic req_n,
    output logic busy,
    output logic fsm_err
);

    logic [5:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rel_pend_q, rel_pend_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= SwRstIdle;
            cnt_q      <= '0;
            rel_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rel_pend_q <= rel_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rel_pend_d = rel_pend_q;
        case (state_q)
            SwRstIdle: begin
                if (wr0) begin
                    state_d    = SwRstHold;
                    cnt_d      = CntW'(MinAssertCycles - 1);
                    rel_pend_d = 1'b0;
                end
            end
            SwRstHold: begin
                if (wr1)      rel_pend_d = 1'b1;
                else if (wr0) rel_pend_d = 1'b0;
                // A release arriving on the final Hold cycle still counts.
                if (cnt_q != '0) cnt_d   = cnt_q - CntW'(1);
                else             state_d = rel_pend_d ? SwRstIdle : SwRstAsserted;
            end
            SwRstAsserted: begin
                if (wr1) state_d = SwRstIdle;
            end
            default: state_d = state_q;
        endcase
    end

    // Illegal codes are not Idle, so the request stays asserted until rst_i.
    always_comb begin
        req_n   = (state_q == SwRstIdle);
        busy    = (state_q == SwRstHold);
        fsm_err = !((state_q == SwRstIdle) || (state_q == SwRstHold) ||
                    (state_q == SwRstAsserted));
    end

endmodule

// File: rtl/rstmgr_sw_rst_ctrl.sv
// Software reset request block: regwen lock, write qualification and per-leaf channels.
module rstmgr_sw_rst_ctrl
    import rstmgr_pkg::*;
#(
    parameter int unsigned NumSwResets     = NumSwResetsDefault,
    parameter int unsigned MinAssertCycles = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ctrl_we_i,
    input  logic [NumSwResets-1:0] ctrl_wdata_i,
    input  logic                   regwen_we_i,
    input  logic [NumSwResets-1:0] regwen_wdata_i,
    output logic [NumSwResets-1:0] regwen_o,
    output logic [NumSwResets-1:0] ctrl_rdata_o,
    output logic [NumSwResets-1:0] sw_rst_req_no,
    output logic [NumSwResets-1:0] busy_o,
    output logic                   fsm_err_o
);

    if (MinAssertCycles < 1) begin : g_bad_param
        $error("MinAssertCycles must be at least 1");
    end

    logic [NumSwResets-1:0] regwen_q;
    logic [NumSwResets-1:0] wr0, wr1;
    logic [NumSwResets-1:0] chan_err;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)            regwen_q <= '1;
        else if (regwen_we_i) regwen_q <= regwen_q & regwen_wdata_i;
    end

    // Qualify with the pre-write lock so a same-cycle lock still lets the ctrl write through.
    assign wr0 = {NumSwResets{ctrl_we_i}} & regwen_q & ~ctrl_wdata_i;
    assign wr1 = {NumSwResets{ctrl_we_i}} & regwen_q &  ctrl_wdata_i;

    for (genvar i = 0; i < NumSwResets; i++) begin : g_chan
        rstmgr_sw_rst_chan #(
            .MinAssertCycles(MinAssertCycles)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .wr0    (wr0[i]),
            .wr1    (wr1[i]),
            .req_n  (sw_rst_req_no[i]),
            .busy   (busy_o[i]),
            .fsm_err(chan_err[i])
        );
    end

    assign regwen_o     = regwen_q;
    assign ctrl_rdata_o = sw_rst_req_no;
    assign fsm_err_o    = |chan_err;

endmodule

// File: tb/tb_rstmgr_sw_rst_ctrl.sv
// Scoreboard bench: stimulus queues hand-computed expectations, a monitor pops and compares.
module tb_rstmgr_sw_rst_ctrl;

    logic       clk_i;
    logic       rst_i;
    logic       ctrl_we_i;
    logic [7:0] ctrl_wdata_i;
    logic       regwen_we_i;
    logic [7:0] regwen_wdata_i;
    logic [7:0] regwen_o;
    logic [7:0] ctrl_rdata_o;
    logic [7:0] sw_rst_req_no;
    logic [7:0] busy_o;
    logic       fsm_err_o;

    rstmgr_sw_rst_ctrl #(
        .NumSwResets    (8),
        .MinAssertCycles(4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ctrl_we_i     (ctrl_we_i),
        .ctrl_wdata_i  (ctrl_wdata_i),
        .regwen_we_i   (regwen_we_i),
        .regwen_wdata_i(regwen_wdata_i),
        .regwen_o      (regwen_o),
        .ctrl_rdata_o  (ctrl_rdata_o),
        .sw_rst_req_no (sw_rst_req_no),
        .busy_o        (busy_o),
        .fsm_err_o     (fsm_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] req;
        logic [7:0] busy;
        logic [7:0] rw;
        logic       err;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    // Monitor: outputs settle #1 after a clock edge or an asynchronous stimulus event.
    always @(posedge clk_i or chk_ev) begin
        #1;
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            n_cmp++;
            if (sw_rst_req_no !== m_e.req || ctrl_rdata_o !== m_e.req ||
                busy_o !== m_e.busy || regwen_o !== m_e.rw || fsm_err_o !== m_e.err) begin
                n_bad++;
                $display("FAIL %s: got req=%h rdata=%h busy=%h regwen=%h err=%b, want req=%h busy=%h regwen=%h err=%b",
                         m_e.nm, sw_rst_req_no, ctrl_rdata_o, busy_o, regwen_o, fsm_err_o,
                         m_e.req, m_e.busy, m_e.rw, m_e.err);
            end
        end
    end

    task automatic push(input logic [7:0] er, input logic [7:0] eb, input logic [7:0] erw,
                        input logic ee, input string nm);
        exp_t e;
        e.req = er; e.busy = eb; e.rw = erw; e.err = ee; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; expectation is for the outputs after the following edge.
    task automatic cyc(input logic cwe, input logic [7:0] cwd, input logic rwe, input logic [7:0] rwd,
                       input logic [7:0] er, input logic [7:0] eb, input logic [7:0] erw,
                       input logic ee, input string nm);
        @(negedge clk_i);
        ctrl_we_i      = cwe;
        ctrl_wdata_i   = cwd;
        regwen_we_i    = rwe;
        regwen_wdata_i = rwd;
        push(er, eb, erw, ee, nm);
    endtask

    task automatic async_chk(input logic [7:0] er, input logic [7:0] eb, input logic [7:0] erw,
                             input logic ee, input string nm);
        push(er, eb, erw, ee, nm);
        -> chk_ev;
        #2;
    endtask

    initial begin
        rst_i          = 1'b1;
        ctrl_we_i      = 1'b0;
        ctrl_wdata_i   = 8'hFF;
        regwen_we_i    = 1'b0;
        regwen_wdata_i = 8'hFF;
        repeat (3) @(negedge clk_i);
        async_chk(8'hFF, 8'h00, 8'hFF, 1'b0, "reset_state");
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 20; i++) cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "idle");

        // Short pulse: release queued during Hold gives exactly 4 low cycles.
        cyc(1, 8'hFE, 0, 8'hFF, 8'hFE, 8'h01, 8'hFF, 0, "short_c1");
        cyc(1, 8'hFF, 0, 8'hFF, 8'hFE, 8'h01, 8'hFF, 0, "short_c2");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFE, 8'h01, 8'hFF, 0, "short_c3");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFE, 8'h01, 8'hFF, 0, "short_c4");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "short_c5");

        // Long hold: Hold for 4 cycles, then Asserted until the release write.
        cyc(1, 8'hFD, 0, 8'hFF, 8'hFD, 8'h02, 8'hFF, 0, "long_enter");
        for (int i = 0; i < 3; i++) cyc(0, 8'hFF, 0, 8'hFF, 8'hFD, 8'h02, 8'hFF, 0, "long_hold");
        for (int i = 0; i < 5; i++) cyc(0, 8'hFF, 0, 8'hFF, 8'hFD, 8'h00, 8'hFF, 0, "long_asserted");
        cyc(1, 8'hFD, 0, 8'hFF, 8'hFD, 8'h00, 8'hFF, 0, "long_rewrite0");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFD, 8'h00, 8'hFF, 0, "long_asserted2");
        cyc(1, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "long_release");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "long_after");

        // Lock behaviour.
        cyc(0, 8'hFF, 1, 8'hFB, 8'hFF, 8'h00, 8'hFB, 0, "lock_bit2");
        cyc(1, 8'hFB, 0, 8'hFF, 8'hFF, 8'h00, 8'hFB, 0, "locked_write");
        cyc(0, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 8'hFB, 0, "regwen_write1");
        cyc(1, 8'hF7, 1, 8'hF7, 8'hF7, 8'h08, 8'hF3, 0, "same_cycle_lock");
        cyc(1, 8'hFF, 0, 8'hFF, 8'hF7, 8'h08, 8'hF3, 0, "locked_release");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hF7, 8'h08, 8'hF3, 0, "lock_hold3");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hF7, 8'h08, 8'hF3, 0, "lock_hold4");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hF7, 8'h00, 8'hF3, 0, "lock_asserted");
        cyc(1, 8'hFF, 0, 8'hFF, 8'hF7, 8'h00, 8'hF3, 0, "lock_stuck");

        // Reset mid-Hold: locked bits 2/3 keep their state until rst_i.
        cyc(1, 8'h00, 0, 8'hFF, 8'h04, 8'hF3, 8'hF3, 0, "all_write0");
        cyc(0, 8'hFF, 0, 8'hFF, 8'h04, 8'hF3, 8'hF3, 0, "all_hold");
        @(negedge clk_i);
        ctrl_we_i = 1'b0;
        #1 rst_i = 1'b1;
        async_chk(8'hFF, 8'h00, 8'hFF, 0, "async_reset");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "reset_held");
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "post_reset");

        // Fault injection on channel 5.
        @(negedge clk_i);
        force dut.g_chan[5].u_chan.state_q = 6'h3F;
        async_chk(8'hDF, 8'h00, 8'hFF, 1, "fault_now");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hDF, 8'h00, 8'hFF, 1, "fault_persist1");
        cyc(1, 8'hFF, 0, 8'hFF, 8'hDF, 8'h00, 8'hFF, 1, "fault_release_wr");
        cyc(0, 8'hFF, 0, 8'hFF, 8'hDF, 8'h00, 8'hFF, 1, "fault_persist2");
        @(negedge clk_i);
        ctrl_we_i = 1'b0;
        rst_i = 1'b1;
        release dut.g_chan[5].u_chan.state_q;
        push(8'hFF, 8'h00, 8'hFF, 0, "fault_cleared");
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc(0, 8'hFF, 0, 8'hFF, 8'hFF, 8'h00, 8'hFF, 0, "final_idle");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rstmgr_sw_rst_ctrl.md
Name: rstmgr_sw_rst_ctrl

Overview:
- Upstream of each software-resettable leaf-reset stage: turns register-interface writes into per-leaf active-low software reset requests, which drive each leaf's sw_rst_req_ni.
- Enforces a per-channel write lock (regwen) and a minimum assertion width, so a software pulse is never shorter than the leaf synchronizer and consistency checker need.
- Runs on the rstmgr main clock; leaf stages resynchronize the outputs.

Parameters:
- NumSwResets, 8, number of software-controllable leaf reset channels.
- MinAssertCycles, 4, minimum cycles a request stays asserted (>=1; elaboration error if 0).
- CntW, $clog2(MinAssertCycles+1), derived counter width (localparam).

Ports:
- clk_i  in  1  main clock.
- rst_i  in  1  asynchronous active-high reset.
- ctrl_we_i  in  1  write strobe for the ctrl register.
- ctrl_wdata_i  in  NumSwResets  per channel: 0 = assert reset, 1 = release.
- regwen_we_i  in  1  write strobe for the regwen register.
- regwen_wdata_i  in  NumSwResets  write-0-to-clear lock bits.
- regwen_o  out  NumSwResets  current regwen (1 = ctrl writable).
- ctrl_rdata_o  out  NumSwResets  readback, equal to sw_rst_req_no.
- sw_rst_req_no  out  NumSwResets  active-low reset requests to leaf stages.
- busy_o  out  NumSwResets  channel in Hold state.
- fsm_err_o  out  1  any channel FSM in an illegal encoding.

Behaviour:
- Reset values: regwen_o all 1; sw_rst_req_no all 1; ctrl_rdata_o all 1; busy_o 0; fsm_err_o 0; all channels Idle, cnt 0, rel_pend 0.
- Regwen:
  - On regwen_we_i, bit i clears when regwen_wdata_i[i]==0. A write of 1 has no effect.
  - Regwen can only be set again by rst_i.
- Ctrl write: channel i sees wr0 = ctrl_we_i & regwen_o[i] & ~ctrl_wdata_i[i] and wr1 = ctrl_we_i & regwen_o[i] & ctrl_wdata_i[i]. When regwen_o[i]==0, ctrl writes to that channel are ignored.
- Per-channel FSM (sparse encoding, Hamming distance >=3). States Idle, Hold, Asserted. sw_rst_req_no[i] is registered and equals (state==Idle).
  - Idle: on wr0, go to Hold, load cnt=MinAssertCycles-1, clear rel_pend. On wr1, no change.
  - Hold:
    - cnt decrements by 1 each cycle while nonzero.
    - wr1 sets rel_pend; wr0 clears rel_pend. A wr0 does not reload cnt.
    - When cnt==0: go to Idle if rel_pend (or wr1 in the same cycle), else go to Asserted.
  - Asserted: on wr1, go to Idle. On wr0, no change.
  - Illegal encoding: assert fsm_err_o (combinational OR over channels) and force sw_rst_req_no[i]=0. Only rst_i recovers; the state is terminal.
- Latency: a write at cycle t is visible on sw_rst_req_no at t+1. With a release already pending, the low pulse is exactly MinAssertCycles cycles. Otherwise it lasts until the cycle after the wr1.
- busy_o[i] = (state==Hold).
- Simultaneous regwen and ctrl writes in the same cycle: the ctrl write uses the pre-write regwen value, so it is honoured.
- If regwen is cleared while a channel is Asserted, that channel stays asserted until rst_i. This is intended.
- rst_i mid-operation: all channels return to Idle asynchronously and outputs go to 1 immediately.
- Channels are fully independent; there is no cross-channel arbitration.

Decomposition:
- rstmgr_pkg gets:
  - sw_rst_state_e: sparse state encoding constants, 6-bit, Idle/Hold/Asserted.
  - Default NumSwResets.
- One natural sub-module, rstmgr_sw_rst_chan: the single-channel FSM, counter and rel_pend. Inputs wr0, wr1; outputs req_n, busy, fsm_err. Instantiated NumSwResets times in a generate loop.
- Top level holds only the regwen register, the write qualification and the fsm_err OR-reduction.

Test Plan:
- Reset then idle: deassert rst_i, no writes -> sw_rst_req_no=8'hFF, regwen_o=8'hFF, busy_o=0, fsm_err_o=0 for 20 cycles.
- Short pulse request: at t, write ctrl 8'hFE; at t+1, write 8'hFF -> bit0 low for exactly cycles t+1..t+4, high at t+5; busy_o[0]=1 for t+1..t+4.
- Long hold: write 8'hFD, wait 10 cycles, write 8'hFF -> bit1 low from t+1 until one cycle after the release write; busy_o[1] drops after 4 cycles.
- Lock: write regwen 8'hFB, then ctrl 8'hFB -> bit2 stays 1. Same-cycle regwen 8'hF7 and ctrl 8'hF7 -> bit3 asserts (pre-write regwen honoured); a later ctrl 8'hFF leaves bit3 low.
- Reset mid-Hold: write 8'h00, assert rst_i at t+2 -> all outputs 1 asynchronously, regwen_o back to 8'hFF.
- Fault injection: force channel 5 state to a non-legal code -> fsm_err_o=1 and sw_rst_req_no[5]=0 in the same cycle; both persist until rst_i.
